uart_rx: RTL and testbench

//  8N1 UART receiver, the receive-side partner of the team's uart_tx.

---
 rtl/uart_rx.sv | 154 +++++++++++++++
 tb/tb_uart_rx.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver sampling at mid-bit from a shared oversampled b_tick
// Synchronises rx, validates the start bit, shifts data LSB first and flags stop-bit errors.
module uart_rx #(
  parameter int OVERSAMPLE  = 16,
  parameter int DATA_BITS   = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 b_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_done,
  output logic                 frame_err,
  output logic                 rx_busy
);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [TW-1:0]          tick_cnt_q, tick_cnt_d;
  logic [BW-1:0]          bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [DATA_BITS-1:0]   rx_data_q, rx_data_d;
  logic                   rx_done_q, rx_done_d;
  logic                   frame_err_q, frame_err_d;
  logic                   rx_busy_q, rx_busy_d;
  logic                   rx_s;

  assign rx_s      = sync_q[SYNC_STAGES-1];
  assign rx_data   = rx_data_q;
  assign rx_done   = rx_done_q;
  assign frame_err = frame_err_q;
  assign rx_busy   = rx_busy_q;

  // Reset to all ones so a reset never looks like a start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      tick_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_done_q   <= 1'b0;
      frame_err_q <= 1'b0;
      rx_busy_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_done_q   <= rx_done_d;
      frame_err_q <= frame_err_d;
      rx_busy_q   <= rx_busy_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    tick_cnt_d  = tick_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_done_d   = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d    = START;
          tick_cnt_d = '0;
        end
      end
      START: begin
        if (b_tick) begin
          if (tick_cnt_q == HALF_LAST) begin
            tick_cnt_d = '0;
            if (!rx_s) begin
              state_d   = DATA;
              bit_cnt_d = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end
      DATA: begin
        if (b_tick) begin
          if (tick_cnt_q == FULL_LAST) begin
            tick_cnt_d = '0;
            shift_d    = {rx_s, shift_q[DATA_BITS-1:1]};
            if (bit_cnt_q == BIT_LAST) begin
              state_d = STOP;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end
      STOP: begin
        if (b_tick) begin
          if (tick_cnt_q == FULL_LAST) begin
            tick_cnt_d = '0;
            if (rx_s) begin
              rx_data_d = shift_q;
              rx_done_d = 1'b1;
              state_d   = IDLE;
            end else begin
              frame_err_d = 1'b1;
              state_d     = WAIT_HIGH;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end
      // A held-low line must return high before another start is accepted.
      WAIT_HIGH: begin
        if (rx_s) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    rx_busy_d = (state_d != IDLE);
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed scoreboard bench for uart_rx
// Drives serial frames on b_tick boundaries and checks received bytes and flags.
module tb_uart_rx;
  localparam int OS = 16;

  logic       clk    = 1'b0;
  logic       rst    = 1'b1;
  logic       b_tick = 1'b0;
  logic       rx     = 1'b1;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       frame_err;
  logic       rx_busy;

  int total    = 0;
  int bad      = 0;
  int gap      = 1;
  int done_cnt = 0;
  int ferr_cnt = 0;
  logic [7:0] exp_q[$];
  logic       prev_pulse = 1'b0;
  logic       busy_chk   = 1'b0;

  uart_rx #(.OVERSAMPLE(OS), .DATA_BITS(8), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .b_tick    (b_tick),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_done   (rx_done),
    .frame_err (frame_err),
    .rx_busy   (rx_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every output pulse is checked as it appears.
  always @(negedge clk) begin
    if (busy_chk) begin
      check("busy_after_done", {31'b0, rx_busy}, 32'd0);
    end
    busy_chk = 1'b0;
    if (rx_done || frame_err) begin
      check("pulse_exclusive", {31'b0, rx_done & frame_err}, 32'd0);
      check("pulse_width", {31'b0, prev_pulse}, 32'd0);
      if (rx_done) begin
        done_cnt++;
        busy_chk = 1'b1;
        check("done_expected", {31'b0, exp_q.size() != 0}, 32'd1);
        if (exp_q.size() != 0) begin
          check("rx_data", {24'b0, rx_data}, {24'b0, exp_q.pop_front()});
        end
      end
      if (frame_err) begin
        ferr_cnt++;
      end
    end
    prev_pulse = rx_done | frame_err;
  end

  // One b_tick period is gap clocks, with b_tick high in the first.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        b_tick = (g == 0);
      end
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input int stop_ticks,
                            input logic good);
    if (good) begin
      exp_q.push_back(d);
    end
    rx = 1'b0;
    tick(OS);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      tick(OS);
    end
    rx = stop;
    tick(stop_ticks);
  endtask

  initial begin
    logic [7:0] part;
    part = 8'h55;
    rst  = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_rx_data", {24'b0, rx_data}, 32'd0);
    check("reset_rx_done", {31'b0, rx_done}, 32'd0);
    check("reset_frame_err", {31'b0, frame_err}, 32'd0);
    check("reset_rx_busy", {31'b0, rx_busy}, 32'd0);
    rst = 1'b0;
    rx  = 1'b1;
    tick(20);

    send_frame(8'hA5, 1'b1, 20, 1'b1);
    check("a5_done_cnt", done_cnt, 32'd1);
    check("a5_ferr_cnt", ferr_cnt, 32'd0);
    check("a5_rx_data", {24'b0, rx_data}, 32'hA5);
    check("a5_busy_idle", {31'b0, rx_busy}, 32'd0);

    rx = 1'b0;
    tick(3);
    rx = 1'b1;
    tick(6);
    check("glitch_busy_in_start", {31'b0, rx_busy}, 32'd1);
    tick(10);
    check("glitch_busy_fell", {31'b0, rx_busy}, 32'd0);
    check("glitch_done_cnt", done_cnt, 32'd1);
    check("glitch_ferr_cnt", ferr_cnt, 32'd0);
    check("glitch_rx_data", {24'b0, rx_data}, 32'hA5);

    send_frame(8'h3C, 1'b0, 40, 1'b0);
    check("ferr_cnt", ferr_cnt, 32'd1);
    check("ferr_done_cnt", done_cnt, 32'd1);
    check("ferr_rx_data", {24'b0, rx_data}, 32'hA5);
    check("ferr_busy_low_line", {31'b0, rx_busy}, 32'd1);
    rx = 1'b1;
    tick(5);
    check("ferr_busy_released", {31'b0, rx_busy}, 32'd0);
    tick(10);

    send_frame(8'h00, 1'b1, 10, 1'b1);
    send_frame(8'hFF, 1'b1, 20, 1'b1);
    check("b2b_done_cnt", done_cnt, 32'd3);
    check("b2b_queue_empty", exp_q.size(), 32'd0);
    check("b2b_ferr_cnt", ferr_cnt, 32'd1);

    rx = 1'b0;
    tick(OS);
    for (int i = 0; i < 4; i++) begin
      rx = part[i];
      tick(OS);
    end
    rx = part[4];
    tick(OS / 2);
    check("mid_busy", {31'b0, rx_busy}, 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_rx_data", {24'b0, rx_data}, 32'd0);
    check("mid_rst_rx_done", {31'b0, rx_done}, 32'd0);
    check("mid_rst_frame_err", {31'b0, frame_err}, 32'd0);
    check("mid_rst_rx_busy", {31'b0, rx_busy}, 32'd0);
    rx = 1'b1;
    tick(4);
    rst = 1'b0;
    tick(20);
    check("post_rst_done_cnt", done_cnt, 32'd3);
    send_frame(8'h81, 1'b1, 20, 1'b1);
    check("post_rst_rx_data", {24'b0, rx_data}, 32'h81);
    check("post_rst_done_cnt2", done_cnt, 32'd4);

    gap = 3;
    tick(5);
    send_frame(8'h5A, 1'b1, OS, 1'b1);
    send_frame(8'hFF, 1'b1, OS, 1'b1);
    send_frame(8'h00, 1'b1, OS, 1'b1);
    tick(20);
    check("loop_done_cnt", done_cnt, 32'd7);
    check("loop_ferr_cnt", ferr_cnt, 32'd1);
    check("loop_queue_empty", exp_q.size(), 32'd0);
    check("loop_rx_data", {24'b0, rx_data}, 32'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
